// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline: datapath widths, ALU operation
// codes and the coarse ALU-type encoding produced by the main decoder.
package riscv_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REGW_DEF = 5;

   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

   typedef enum logic [1:0] {
      ALU_T_ADD   = 2'b00,
      ALU_T_SUB   = 2'b01,
      ALU_T_FUNCT = 2'b10,
      ALU_T_RSVD  = 2'b11
   } alu_type_e;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU decode: coarse ALU type plus funct3/funct7[5] to the
// 4-bit ALU operation code. Unsupported combinations yield ALU_ILLEGAL.
module alu_control
   import riscv_pkg::*;
(
   input  logic [1:0] alu_type,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [3:0] alu_op
);

   always_comb begin
      alu_op = ALU_ILLEGAL;
      case (alu_type_e'(alu_type))
         ALU_T_ADD:  alu_op = ALU_ADD;
         ALU_T_SUB:  alu_op = ALU_SUB;
         ALU_T_FUNCT: begin
            case (funct3)
               // funct7[5] only selects SUB for register-register forms;
               // for I-type it is an immediate bit.
               3'b000:  alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b111:  alu_op = ALU_AND;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_ILLEGAL;
            endcase
         end
         default:    alu_op = ALU_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-code decode, EX/MEM and MEM/WB operand
// forwarding into the ALU, and combinational load-use hazard detection.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic [1:0]      id_alu_type,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic            id_is_rtype,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic [REGW-1:0] exmem_rd,
   input  logic            exmem_regwrite,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [REGW-1:0] memwb_rd,
   input  logic            memwb_regwrite,
   input  logic [XLEN-1:0] memwb_result,
   output logic [3:0]      ALUop,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_valid,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic            illegal_alu,
   output logic            load_use_stall
);

   // Valid semantics: an EX slot carries an instruction only while ex_valid is
   // high; control outputs are masked by it, data fields are don't-care otherwise.
   // There is no ready: the upstream controller turns load_use_stall into
   // stall plus flush, this stage never stalls itself.

   logic [3:0]      id_alu_op;
   logic            valid_q;
   logic [REGW-1:0] rs1_q, rs2_q, rd_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
   logic            alu_src_q;
   logic [3:0]      alu_op_q;
   logic            regwrite_q, memread_q, memwrite_q;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   alu_control u_alu_control (
      .alu_type (id_alu_type),
      .funct3   (id_funct3),
      .funct7b5 (id_funct7b5),
      .is_rtype (id_is_rtype),
      .alu_op   (id_alu_op)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         alu_src_q  <= 1'b0;
         alu_op_q   <= '0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else if (flush) begin
         // Bubble: only control is cleared, data fields keep stale values.
         valid_q    <= 1'b0;
         alu_op_q   <= ALU_ADD;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else if (!stall) begin
         valid_q    <= id_valid;
         rs1_q      <= id_rs1;
         rs2_q      <= id_rs2;
         rd_q       <= id_rd;
         rs1_data_q <= id_rs1_data;
         rs2_data_q <= id_rs2_data;
         imm_q      <= id_imm;
         alu_src_q  <= id_alu_src;
         alu_op_q   <= id_alu_op;
         regwrite_q <= id_regwrite;
         memread_q  <= id_memread;
         memwrite_q <= id_memwrite;
      end
   end

   // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs1_q))
         fwd_rs1 = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs1_q))
         fwd_rs1 = memwb_result;
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs2_q))
         fwd_rs2 = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs2_q))
         fwd_rs2 = memwb_result;
   end

   assign op1           = fwd_rs1;
   assign op2           = alu_src_q ? imm_q : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ALUop         = alu_op_q;

   assign ex_valid    = valid_q;
   assign ex_rd       = rd_q;
   assign ex_regwrite = regwrite_q & valid_q;
   assign ex_memread  = memread_q  & valid_q;
   assign ex_memwrite = memwrite_q & valid_q;
   assign illegal_alu = valid_q & (alu_op_q == ALU_ILLEGAL);

   assign load_use_stall = valid_q & memread_q & (rd_q != '0) & id_valid &
                           ((rd_q == id_rs1) | (rd_q == id_rs2));

endmodule
